// File: rtl/sdram_cpu_arbiter.sv
// Arbiter sharing the sdram_snes CPU slot between SNES CPU (A), coprocessor (B) and loader (C).
// Define SDRAM_ARB_RR_EN for round-robin selection; otherwise fixed priority A > B > C.
module sdram_cpu_arbiter #(
  parameter int AW = 22,
  parameter int DW = 16
) (
  input  logic          mclk,
  input  logic          resetn,
  input  logic          a_req,
  input  logic          b_req,
  input  logic          c_req,
  output logic          a_ack,
  output logic          b_ack,
  output logic          c_ack,
  input  logic [AW:1]   a_addr,
  input  logic [DW-1:0] a_din,
  input  logic          a_we,
  input  logic [1:0]    a_ds,
  input  logic [AW:1]   b_addr,
  input  logic [DW-1:0] b_din,
  input  logic          b_we,
  input  logic [1:0]    b_ds,
  input  logic [AW:1]   c_addr,
  input  logic [DW-1:0] c_din,
  input  logic          c_we,
  input  logic [1:0]    c_ds,
  output logic [DW-1:0] a_dout,
  output logic [DW-1:0] b_dout,
  output logic [DW-1:0] c_dout,
  output logic          dn_req,
  input  logic          dn_ack,
  output logic [AW:1]   dn_addr,
  output logic [DW-1:0] dn_din,
  output logic          dn_we,
  output logic [1:0]    dn_ds,
  input  logic [DW-1:0] dn_dout,
  output logic [1:0]    grant
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t     state, state_nxt;
  logic [2:0] pend;
  logic [1:0] sel;
  logic       start, done;
  logic       tag;

  assign pend = {c_req ^ c_ack, b_req ^ b_ack, a_req ^ a_ack};

  function automatic logic [1:0] pick_fixed(input logic [2:0] p);
    if (p[0])      return 2'd1;
    else if (p[1]) return 2'd2;
    else if (p[2]) return 2'd3;
    else           return 2'd0;
  endfunction

`ifdef SDRAM_ARB_RR_EN
  logic [1:0] last;

  // Search starts just after the last winner, wrapping C back to A.
  function automatic logic [1:0] pick_rr(input logic [2:0] p, input logic [1:0] l);
    case (l)
      2'd1:    return p[1] ? 2'd2 : p[2] ? 2'd3 : p[0] ? 2'd1 : 2'd0;
      2'd2:    return p[2] ? 2'd3 : p[0] ? 2'd1 : p[1] ? 2'd2 : 2'd0;
      default: return pick_fixed(p);
    endcase
  endfunction

  always_ff @(posedge mclk) begin
    if (!resetn)    last <= 2'd3;
    else if (start) last <= sel;
  end

  assign sel = pick_rr(pend, last);
`else
  assign sel = pick_fixed(pend);
`endif

  always_ff @(posedge mclk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (sel != 2'd0) begin
        start     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: if (dn_ack == dn_req) begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant edge: register the winner's command toward the slot.
  always_ff @(posedge mclk) begin
    if (!resetn) begin
      dn_req  <= 1'b0;
      dn_addr <= '0;
      dn_din  <= '0;
      dn_we   <= 1'b0;
      dn_ds   <= 2'b00;
      tag     <= 1'b0;
      grant   <= 2'd0;
    end else if (start) begin
      dn_req <= ~dn_req;
      grant  <= sel;
      case (sel)
        2'd1: begin
          dn_addr <= a_addr; dn_din <= a_din; dn_we <= a_we; dn_ds <= a_ds; tag <= a_req;
        end
        2'd2: begin
          dn_addr <= b_addr; dn_din <= b_din; dn_we <= b_we; dn_ds <= b_ds; tag <= b_req;
        end
        default: begin
          dn_addr <= c_addr; dn_din <= c_din; dn_we <= c_we; dn_ds <= c_ds; tag <= c_req;
        end
      endcase
    end else if (done) begin
      grant <= 2'd0;
    end
  end

  // Completion edge: only the granted requester's ack and read data move.
  always_ff @(posedge mclk) begin
    if (!resetn) begin
      a_ack  <= 1'b0;
      b_ack  <= 1'b0;
      c_ack  <= 1'b0;
      a_dout <= '0;
      b_dout <= '0;
      c_dout <= '0;
    end else if (done) begin
      case (grant)
        2'd1: begin
          a_ack <= tag;
          if (!dn_we) a_dout <= dn_dout;
        end
        2'd2: begin
          b_ack <= tag;
          if (!dn_we) b_dout <= dn_dout;
        end
        2'd3: begin
          c_ack <= tag;
          if (!dn_we) c_dout <= dn_dout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_cpu_arbiter.sv
// Directed bench for sdram_cpu_arbiter with a 3-cycle toggle-ack slot model.
module tb_sdram_cpu_arbiter;
  localparam int AW = 22;
  localparam int DW = 16;

  logic          mclk = 1'b0;
  logic          resetn;
  logic          a_req, b_req, c_req;
  logic          a_ack, b_ack, c_ack;
  logic [AW:1]   a_addr, b_addr, c_addr;
  logic [DW-1:0] a_din, b_din, c_din;
  logic          a_we, b_we, c_we;
  logic [1:0]    a_ds, b_ds, c_ds;
  logic [DW-1:0] a_dout, b_dout, c_dout;
  logic          dn_req, dn_ack;
  logic [AW:1]   dn_addr;
  logic [DW-1:0] dn_din;
  logic          dn_we;
  logic [1:0]    dn_ds;
  logic [DW-1:0] dn_dout;
  logic [1:0]    grant;
  logic [2:0]    slot_dly;

  int errors = 0;
  int checks = 0;

  sdram_cpu_arbiter #(.AW(AW), .DW(DW)) dut (
    .mclk(mclk), .resetn(resetn),
    .a_req(a_req), .b_req(b_req), .c_req(c_req),
    .a_ack(a_ack), .b_ack(b_ack), .c_ack(c_ack),
    .a_addr(a_addr), .a_din(a_din), .a_we(a_we), .a_ds(a_ds),
    .b_addr(b_addr), .b_din(b_din), .b_we(b_we), .b_ds(b_ds),
    .c_addr(c_addr), .c_din(c_din), .c_we(c_we), .c_ds(c_ds),
    .a_dout(a_dout), .b_dout(b_dout), .c_dout(c_dout),
    .dn_req(dn_req), .dn_ack(dn_ack),
    .dn_addr(dn_addr), .dn_din(dn_din), .dn_we(dn_we), .dn_ds(dn_ds),
    .dn_dout(dn_dout), .grant(grant)
  );

  always #5 mclk = ~mclk;

  // Slot: ack follows req three cycles later; read data from a tiny fixed memory image.
  always_ff @(posedge mclk) begin
    if (!resetn) slot_dly <= 3'b000;
    else         slot_dly <= {slot_dly[1:0], dn_req};
  end
  assign dn_ack  = slot_dly[2];
  assign dn_dout = (dn_addr == 22'h012345) ? 16'hBEEF : (16'h5A5A ^ dn_addr[16:1]);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  function automatic logic pend_of(input int i);
    case (i)
      0:       return a_req ^ a_ack;
      1:       return b_req ^ b_ack;
      default: return c_req ^ c_ack;
    endcase
  endfunction

  task automatic wait_done(input int i, output int n);
    n = 0;
    while (pend_of(i) && n < 40) begin
      tick();
      n++;
    end
  endtask

  int n;
  int ord [3];
  int gaps[2];
  int ord_n, gap;
  logic [1:0] prev;
  int a_cnt, a_before_b;
  logic b_seen;

  initial begin
    resetn = 1'b0;
    a_req = 0; b_req = 0; c_req = 0;
    a_addr = '0; b_addr = '0; c_addr = '0;
    a_din = '0; b_din = '0; c_din = '0;
    a_we = 0; b_we = 0; c_we = 0;
    a_ds = 2'b11; b_ds = 2'b11; c_ds = 2'b11;
    repeat (4) tick();
    chk("rst_a_ack", a_ack, 0);
    chk("rst_b_ack", b_ack, 0);
    chk("rst_c_ack", c_ack, 0);
    chk("rst_dn_req", dn_req, 0);
    chk("rst_grant", grant, 0);
    chk("rst_douts", {a_dout, b_dout, c_dout}, 0);
    chk("rst_dn_cmd", {dn_addr, dn_we, dn_ds}, 0);
    resetn = 1'b1;
    tick();

    // A read: latency from toggle to ack is 5 edges
    a_addr = 22'h000100; a_we = 0; a_req = 1;
    tick();
    chk("a_dn_req", dn_req, 1);
    chk("a_grant", grant, 1);
    chk("a_dn_addr", dn_addr, 22'h000100);
    wait_done(0, n);
    chk("a_latency", n + 1, 5);
    chk("a_ack", a_ack, 1);
    chk("a_dout", a_dout, 16'h5B5A);
    chk("a_grant_clr", grant, 0);

    // B read routed to b_dout only
    b_addr = 22'h012345; b_we = 0; b_req = 1;
    tick();
    chk("b_grant", grant, 2);
    chk("b_dn_addr", dn_addr, 22'h012345);
    chk("b_dn_we", dn_we, 0);
    wait_done(1, n);
    chk("b_ack", b_ack, 1);
    chk("b_dout", b_dout, 16'hBEEF);
    chk("b_a_dout_kept", a_dout, 16'h5B5A);
    chk("b_c_dout_kept", c_dout, 0);

    // C write leaves c_dout alone
    c_addr = 22'h000200; c_din = 16'h00AA; c_ds = 2'b01; c_we = 1; c_req = 1;
    tick();
    chk("c_grant", grant, 3);
    chk("c_dn_we", dn_we, 1);
    chk("c_dn_ds", dn_ds, 2'b01);
    chk("c_dn_din", dn_din, 16'h00AA);
    wait_done(2, n);
    chk("c_ack", c_ack, 1);
    chk("c_dout_kept", c_dout, 0);
    chk("c_b_dout_kept", b_dout, 16'hBEEF);

    // One more A so the last winner is A
    a_req = 0;
    wait_done(0, n);
    chk("a2_ack", a_ack, 0);

    // Simultaneous A, B, C
    c_we = 0;
    a_req = ~a_req; b_req = ~b_req; c_req = ~c_req;
    ord_n = 0; gap = 0; prev = 0; n = 0;
    while ((pend_of(0) || pend_of(1) || pend_of(2)) && n < 80) begin
      tick();
      n++;
      if (grant != 0 && prev == 0) begin
        if (ord_n < 3) ord[ord_n] = int'(grant);
        if (ord_n > 0 && ord_n < 3) gaps[ord_n-1] = gap;
        ord_n++;
        gap = 0;
      end else if (grant == 0) begin
        gap++;
      end
      prev = grant;
    end
    chk("sim_grants", ord_n, 3);
`ifdef SDRAM_ARB_RR_EN
    chk("sim_ord0", ord[0], 2);
    chk("sim_ord1", ord[1], 3);
    chk("sim_ord2", ord[2], 1);
`else
    chk("sim_ord0", ord[0], 1);
    chk("sim_ord1", ord[1], 2);
    chk("sim_ord2", ord[2], 3);
`endif
    chk("sim_gap0", gaps[0], 1);
    chk("sim_gap1", gaps[1], 1);
    chk("sim_no_loss", {a_req ^ a_ack, b_req ^ b_ack, c_req ^ c_ack}, 0);

    // A re-toggles on every ack while B waits
    a_cnt = 0; a_before_b = 0; b_seen = 0; prev = 0; n = 0;
    a_req = ~a_req; b_req = ~b_req;
    while (!(a_cnt >= 20 && !pend_of(0)) && n < 300) begin
      tick();
      n++;
      if (grant == 1 && prev != 1) a_cnt++;
      if (grant == 2 && !b_seen) begin
        b_seen = 1;
        a_before_b = a_cnt;
      end
      prev = grant;
      if (!pend_of(0) && a_cnt < 20) a_req = ~a_req;
    end
    chk("starve_a_cnt", a_cnt, 20);
`ifdef SDRAM_ARB_RR_EN
    chk("rr_b_granted", b_seen, 1);
    chk("rr_b_wait", (a_before_b <= 1), 1);
`else
    chk("fixed_b_starved", b_seen, 0);
    chk("fixed_b_pend", b_req ^ b_ack, 1);
`endif
    wait_done(1, n);
    chk("starve_b_done", b_req ^ b_ack, 0);

    // Reset in the middle of WAIT
    a_req = ~a_req;
    tick();
    chk("mid_grant", grant, 1);
    tick();
    resetn = 0; a_req = 0; b_req = 0; c_req = 0;
    tick();
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_dn_req", dn_req, 0);
    chk("mid_rst_acks", {a_ack, b_ack, c_ack}, 0);
    chk("mid_rst_a_dout", a_dout, 0);
    tick();
    resetn = 1;
    tick();
    a_addr = 22'h000100; a_we = 0; a_req = 1;
    tick();
    chk("post_rst_grant", grant, 1);
    wait_done(0, n);
    chk("post_rst_latency", n + 1, 5);
    chk("post_rst_a_dout", a_dout, 16'h5B5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sdram_cpu_arbiter.md
# sdram_cpu_arbiter

Shares the single CPU slot of `sdram_snes` between three toggle-handshake requesters:
- A: SNES CPU (ROM/WRAM)
- B: coprocessor (GSU/SA-1)
- C: RISC-V loader

It grants one requester at a time, forwards that requester's address, data and strobes to the slot, and routes read data back into a per-requester output register. Acks are toggle-style, identical to the SDRAM controller convention.

## Interface
Parameters:
- `AW`, 22, word-address MSB; addresses are `[AW:1]`
- `DW`, 16, data width

Ports:
- `mclk` in 1: clock
- `resetn` in 1: reset, synchronous, active-low; clock mclk
- `a_req`, `b_req`, `c_req` in 1 each: request toggles
- `a_ack`, `b_ack`, `c_ack` out 1 each: ack toggles; equal to the matching req when that request has completed
- `x_addr` in [AW:1], `x_din` in DW, `x_we` in 1, `x_ds` in 2: per-requester command, for x = a, b, c
- `x_dout` out DW: per-requester read data register
- `dn_req` out 1: toggle to the SDRAM CPU slot
- `dn_ack` in 1: slot ack toggle
- `dn_addr` out [AW:1], `dn_din` out DW, `dn_we` out 1, `dn_ds` out 2: latched command to the slot
- `dn_dout` in DW: slot read data, valid when `dn_ack==dn_req`
- `grant` out 2: 0 = none, 1 = A, 2 = B, 3 = C (debug/status)

## Operation
- Pending: `x_pend = x_req ^ x_ack`.
- The requester must hold its command stable from its req toggle until its ack toggles. A second toggle before the ack is a protocol violation; behaviour is undefined, but a request already granted still completes.
- FSM has two states: IDLE and WAIT.
- IDLE, any pending:
  - select the winner;
  - latch its addr/din/we/ds into the `dn_*` registers;
  - store the winner's current req value in `tag`;
  - toggle `dn_req`; set `grant`; go to WAIT.
- WAIT, `dn_ack==dn_req`:
  - if `dn_we==0`, copy `dn_dout` into the granted `x_dout`;
  - set the granted `x_ack <= tag`;
  - set `grant <= 0`; return to IDLE.
- Writes never change `x_dout`.
- Default selection is fixed priority A > B > C.
- Only the granted requester's ack or dout changes in any cycle.
- `dn_ds` passes through unchanged. Byte-lane handling belongs to the SDRAM controller.

## Timing
- Reset values:
  - state IDLE, `grant` 0, `dn_req` 0
  - `a_ack`, `b_ack`, `c_ack` = 0
  - `x_dout` = 0
  - `dn_addr`, `dn_din`, `dn_ds` = 0; `dn_we` = 0
- Requesters and the SDRAM controller share `resetn`, so all toggles restart at 0 together.
- Reset asserted mid-WAIT abandons the transaction: no ack and no dout update.
- A pending request seen at edge N gives `dn_req` toggled and `dn_*` valid after edge N. The command is registered, so there is no combinational path from `x_*` to `dn_*`.
- When `dn_ack==dn_req` is first sampled at edge M, `x_ack` and `x_dout` update at edge M.
- The next grant happens no earlier than edge M+1. There is exactly one IDLE cycle between transactions.
- Total requester latency is slot latency + 2 mclk. With the controller's 3-phase slot, that is 5 mclk worst case when uncontended.
- Simultaneous pendings: one grant per IDLE visit. Losers stay pending with no loss.
- A request arriving while WAIT is active is evaluated at the next IDLE.
- A request arriving on the completion edge M is eligible at M+1.

## Configuration
- `SDRAM_ARB_RR_EN` defined: round-robin selection.
  - A 2-bit `last` register holds the last granted index, reset to C.
  - Search order starts at the requester after `last`, wrapping C → A.
  - No requester waits more than 2 other grants.
- Not defined: fixed priority A > B > C. `last` is not implemented, and B/C can starve under continuous A traffic.

## Test plan
- Reset: hold `resetn` low 4 cycles → all acks 0, `dn_req` 0, `grant` 0, `x_dout` 0. Then toggle `a_req` with `dn_ack` tied to `dn_req` delayed 3 cycles → `a_ack` 1 exactly 5 edges after the toggle.
- Read routing: preload 0xBEEF at B address 0x12345. Toggle `b_req` with `b_we=0` → `dn_addr=0x12345`, `b_dout=0xBEEF` when `b_ack` flips; `a_dout` and `c_dout` unchanged.
- Write: C writes 0x00AA with `c_ds=01` → `dn_we=1`, `dn_ds=01`, `dn_din=0x00AA`; `c_dout` unchanged; `c_ack` toggles.
- Simultaneous requests: toggle A, B and C on the same edge.
  - Without the macro: grant order A, B, C.
  - With `SDRAM_ARB_RR_EN` and `last` = A: grant order B, C, A.
  - Exactly one IDLE cycle between grants in both cases.
- Starvation: A toggles again every cycle its ack flips, while B is pending.
  - Without the macro: B is never granted over 20 A transactions.
  - With the macro: B is granted after at most 1 A grant.
- Reset mid-operation: assert `resetn` while in WAIT → no ack toggles, state IDLE, `dn_req` 0 on the next cycle.
